// File: rtl/core101_pkg.sv
// rtl/core101_pkg.sv - shared fetch-stage state encoding and width defaults
package core101_pkg;

    localparam int XLEN_DEFAULT = 32;

    typedef enum logic [1:0] {
        FETCH_IDLE     = 2'd0,
        FETCH_REQ      = 2'd1,
        FETCH_WAIT_DEC = 2'd2,
        FETCH_DROP     = 2'd3
    } fetch_state_e;

endpackage

// File: rtl/fetch_skid_buf.sv
// rtl/fetch_skid_buf.sv - one-entry instruction holding buffer with load/clear and full flag
module fetch_skid_buf
    import core101_pkg::*;
#(
    parameter int XLEN = XLEN_DEFAULT
) (
    input  logic            clock_in,
    input  logic            reset_in,
    input  logic            load,
    input  logic            clear,
    input  logic [XLEN-1:0] load_data,
    output logic [XLEN-1:0] data,
    output logic            full
);

    always_ff @(posedge clock_in) begin
        if (!reset_in) begin
            full <= 1'b0;
            data <= '0;
        end else if (clear) begin
            full <= 1'b0;
        end else if (load) begin
            full <= 1'b1;
            data <= load_data;
        end
    end

endmodule

// File: rtl/fetch_ctrl.sv
// rtl/fetch_ctrl.sv - instruction-fetch handshake, IF/DEC load/clear, skid and flush-drop control
// Optional FETCH_CTRL_PERF_EN adds fetched-instruction and stall-cycle counters.
module fetch_ctrl
    import core101_pkg::*;
#(
    parameter int XLEN        = XLEN_DEFAULT,
    parameter int MEM_TIMEOUT = 255
) (
    input  logic            clock_in,
    input  logic            reset_in,
    input  logic [XLEN-1:0] fetch_pc_in,
    input  logic            fetch_flush_in,
    input  logic            fetch_dec_stall_in,
    output logic            ins_mem_valid_out,
    output logic [XLEN-1:0] ins_mem_addr_out,
    input  logic            ins_mem_ready_in,
    input  logic [XLEN-1:0] ins_mem_data_in,
    output logic            fetch_pc_set_out,
    output logic            fetch_if_dec_set_out,
    output logic            fetch_if_dec_clear_out,
    output logic [XLEN-1:0] fetch_ins_out,
    output logic            fetch_timeout_out
`ifdef FETCH_CTRL_PERF_EN
    ,
    output logic [31:0]     fetch_perf_ins_out,
    output logic [31:0]     fetch_perf_stall_out
`endif
);

    localparam int            CW          = $clog2(MEM_TIMEOUT + 1);
    localparam logic [CW-1:0] TIMEOUT_LIM = CW'(MEM_TIMEOUT);

    fetch_state_e    state_q, state_d;
    logic [XLEN-1:0] held_addr_q;
    logic [CW-1:0]   timeout_cnt_q;
    logic [CW-1:0]   timeout_inc;
    logic            timeout_q;

    logic            valid, pc_set, if_dec_set, if_dec_clear;
    logic [XLEN-1:0] addr, ins;
    logic            buf_load, buf_clear, buf_full, held_load;
    logic [XLEN-1:0] buf_data;

    fetch_skid_buf #(.XLEN(XLEN)) u_skid (
        .clock_in  (clock_in),
        .reset_in  (reset_in),
        .load      (buf_load),
        .clear     (buf_clear),
        .load_data (ins_mem_data_in),
        .data      (buf_data),
        .full      (buf_full)
    );

    always_ff @(posedge clock_in) begin
        if (!reset_in) begin
            state_q     <= FETCH_IDLE;
            held_addr_q <= '0;
        end else begin
            state_q <= state_d;
            if (held_load) begin
                held_addr_q <= fetch_pc_in;
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        valid        = 1'b0;
        addr         = '0;
        pc_set       = 1'b0;
        if_dec_set   = 1'b0;
        if_dec_clear = 1'b0;
        ins          = buf_full ? buf_data : '0;
        buf_load     = 1'b0;
        buf_clear    = 1'b0;
        held_load    = 1'b0;
        unique case (state_q)
            FETCH_IDLE: state_d = FETCH_REQ;
            FETCH_REQ: begin
                valid = 1'b1;
                addr  = fetch_pc_in;
                if (ins_mem_ready_in) begin
                    pc_set = 1'b1;
                    if (fetch_flush_in) begin
                        if_dec_clear = 1'b1;
                    end else if (fetch_dec_stall_in) begin
                        buf_load = 1'b1;
                        state_d  = FETCH_WAIT_DEC;
                    end else begin
                        if_dec_set = 1'b1;
                        ins        = ins_mem_data_in;
                    end
                end else if (fetch_flush_in) begin
                    // The request stays outstanding; remember its address so it is not withdrawn.
                    held_load    = 1'b1;
                    if_dec_clear = 1'b1;
                    pc_set       = 1'b1;
                    state_d      = FETCH_DROP;
                end
            end
            FETCH_WAIT_DEC: begin
                if (fetch_flush_in) begin
                    buf_clear    = 1'b1;
                    if_dec_clear = 1'b1;
                    pc_set       = 1'b1;
                    state_d      = FETCH_REQ;
                end else if (!fetch_dec_stall_in) begin
                    buf_clear  = 1'b1;
                    if_dec_set = 1'b1;
                    state_d    = FETCH_REQ;
                end
            end
            FETCH_DROP: begin
                valid = 1'b1;
                addr  = held_addr_q;
                if (fetch_flush_in) begin
                    if_dec_clear = 1'b1;
                    pc_set       = 1'b1;
                end
                if (ins_mem_ready_in) begin
                    state_d = FETCH_REQ;
                end
            end
            default: state_d = FETCH_IDLE;
        endcase
    end

    assign timeout_inc = (timeout_cnt_q == {CW{1'b1}}) ? timeout_cnt_q : timeout_cnt_q + CW'(1);

    always_ff @(posedge clock_in) begin
        if (!reset_in) begin
            timeout_cnt_q <= '0;
            timeout_q     <= 1'b0;
        end else if (valid) begin
            if (ins_mem_ready_in) begin
                timeout_cnt_q <= '0;
            end else begin
                timeout_cnt_q <= timeout_inc;
                if (timeout_inc >= TIMEOUT_LIM) begin
                    timeout_q <= 1'b1;
                end
            end
        end
    end

    // Outputs are forced low while reset is held so an abandoned request drops immediately.
    assign ins_mem_valid_out      = reset_in & valid;
    assign ins_mem_addr_out       = reset_in ? addr : '0;
    assign fetch_pc_set_out       = reset_in & pc_set;
    assign fetch_if_dec_set_out   = reset_in & if_dec_set;
    assign fetch_if_dec_clear_out = reset_in & if_dec_clear;
    assign fetch_ins_out          = reset_in ? ins : '0;
    assign fetch_timeout_out      = reset_in & timeout_q;

`ifdef FETCH_CTRL_PERF_EN
    logic [31:0] perf_ins_q, perf_stall_q;
    logic        stall_cycle;

    assign stall_cycle = (((state_q == FETCH_REQ) || (state_q == FETCH_DROP)) && !ins_mem_ready_in)
                       || (state_q == FETCH_WAIT_DEC);

    always_ff @(posedge clock_in) begin
        if (!reset_in) begin
            perf_ins_q   <= '0;
            perf_stall_q <= '0;
        end else begin
            if (if_dec_set) begin
                perf_ins_q <= perf_ins_q + 32'd1;
            end
            if (stall_cycle) begin
                perf_stall_q <= perf_stall_q + 32'd1;
            end
        end
    end

    assign fetch_perf_ins_out   = reset_in ? perf_ins_q : '0;
    assign fetch_perf_stall_out = reset_in ? perf_stall_q : '0;
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
// tb/tb_fetch_ctrl.sv - scoreboard bench for fetch_ctrl with directed fetch/stall/flush/timeout vectors
module tb_fetch_ctrl;

    logic        clk = 1'b0;
    logic        resetn;
    logic [31:0] pc_in;
    logic        flush, stall;
    logic        valid;
    logic [31:0] addr;
    logic        ready;
    logic [31:0] data;
    logic        pc_set, dec_set, dec_clear;
    logic [31:0] ins;
    logic        timeout;
`ifdef FETCH_CTRL_PERF_EN
    logic [31:0] perf_ins, perf_stall;
`endif

    typedef struct {
        logic        is_set;
        logic [31:0] ins;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    fetch_ctrl #(.XLEN(32), .MEM_TIMEOUT(4)) dut (
        .clock_in               (clk),
        .reset_in               (resetn),
        .fetch_pc_in            (pc_in),
        .fetch_flush_in         (flush),
        .fetch_dec_stall_in     (stall),
        .ins_mem_valid_out      (valid),
        .ins_mem_addr_out       (addr),
        .ins_mem_ready_in       (ready),
        .ins_mem_data_in        (data),
        .fetch_pc_set_out       (pc_set),
        .fetch_if_dec_set_out   (dec_set),
        .fetch_if_dec_clear_out (dec_clear),
        .fetch_ins_out          (ins),
        .fetch_timeout_out      (timeout)
`ifdef FETCH_CTRL_PERF_EN
        ,
        .fetch_perf_ins_out     (perf_ins),
        .fetch_perf_stall_out   (perf_stall)
`endif
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic [31:0] d, input logic s, input logic f,
                         input logic [31:0] pc);
        ready = r;
        data  = d;
        stall = s;
        flush = f;
        pc_in = pc;
    endtask

    task automatic push_set(input logic [31:0] v);
        exp_t e;
        e.is_set = 1'b1;
        e.ins    = v;
        exp_q.push_back(e);
    endtask

    task automatic push_clear();
        exp_t e;
        e.is_set = 1'b0;
        e.ins    = 32'h0;
        exp_q.push_back(e);
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Monitor: every IF/DEC load or clear must match the next queued expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (dec_set || dec_clear) begin
                chk("set_clear_exclusive", {31'd0, dec_set & dec_clear}, 32'd0);
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_ifdec_event: got set=%0b clear=%0b ins=0x%08h expected none",
                             dec_set, dec_clear, ins);
                end else begin
                    e = exp_q.pop_front();
                    chk("ifdec_kind_set", {31'd0, dec_set}, {31'd0, e.is_set});
                    if (e.is_set) begin
                        chk("ifdec_ins", ins, e.ins);
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        resetn = 1'b0;
        drive(1'b1, 32'h0, 1'b0, 1'b0, 32'h0);
        repeat (3) next_cycle();
        @(negedge clk);
        chk("reset_valid", {31'd0, valid}, 32'd0);
        chk("reset_pc_set", {31'd0, pc_set}, 32'd0);
        chk("reset_timeout", {31'd0, timeout}, 32'd0);
        next_cycle();

        // 1: reset release, ready tied high, back-to-back fetches
        resetn = 1'b1;
        drive(1'b1, 32'h0000_0011, 1'b0, 1'b0, 32'h0);
        @(negedge clk);
        chk("idle_valid", {31'd0, valid}, 32'd0);
        next_cycle();
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 32'h0000_0011 * (i + 1), 1'b0, 1'b0, 32'(i * 4));
            push_set(32'h0000_0011 * (i + 1));
            @(negedge clk);
            chk("t1_valid", {31'd0, valid}, 32'd1);
            chk("t1_addr", addr, 32'(i * 4));
            chk("t1_pc_set", {31'd0, pc_set}, 32'd1);
            next_cycle();
        end

        // 2: three unanswered cycles then handshake
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 32'hFFFF_FFFF, 1'b0, 1'b0, 32'h100);
            @(negedge clk);
            chk("t2_addr_hold", addr, 32'h100);
            chk("t2_pc_set", {31'd0, pc_set}, 32'd0);
            next_cycle();
        end
        drive(1'b1, 32'h0050_0093, 1'b0, 1'b0, 32'h100);
        push_set(32'h0050_0093);
        @(negedge clk);
        chk("t2_pc_set_hs", {31'd0, pc_set}, 32'd1);
        chk("t2_no_timeout", {31'd0, timeout}, 32'd0);
        next_cycle();

        // 3: response captured while decode stalled
        drive(1'b1, 32'hDEAD_BEEF, 1'b1, 1'b0, 32'h104);
        @(negedge clk);
        chk("t3_pc_set", {31'd0, pc_set}, 32'd1);
        next_cycle();
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 32'h1234_5678, 1'b1, 1'b0, 32'h108);
            @(negedge clk);
            chk("t3_wait_valid", {31'd0, valid}, 32'd0);
            next_cycle();
        end
        drive(1'b1, 32'h1234_5678, 1'b0, 1'b0, 32'h108);
        push_set(32'hDEAD_BEEF);
        @(negedge clk);
        chk("t3_release_valid", {31'd0, valid}, 32'd0);
        next_cycle();

        // 4: flush with request outstanding
        drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h200);
        @(negedge clk);
        chk("t4_addr", addr, 32'h200);
        next_cycle();
        drive(1'b0, 32'h0, 1'b0, 1'b1, 32'h200);
        push_clear();
        @(negedge clk);
        chk("t4_flush_pc_set", {31'd0, pc_set}, 32'd1);
        next_cycle();
        drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h400);
        @(negedge clk);
        chk("t4_drop_addr", addr, 32'h200);
        chk("t4_drop_valid", {31'd0, valid}, 32'd1);
        chk("t4_drop_pc_set", {31'd0, pc_set}, 32'd0);
        next_cycle();
        drive(1'b1, 32'hBAD0_BAD0, 1'b0, 1'b0, 32'h400);
        @(negedge clk);
        chk("t4_drop_addr_ready", addr, 32'h200);
        next_cycle();
        drive(1'b1, 32'h0000_0413, 1'b0, 1'b0, 32'h400);
        push_set(32'h0000_0413);
        @(negedge clk);
        chk("t4_redirect_addr", addr, 32'h400);
        next_cycle();

        // 5: flush together with stall in WAIT_DEC, then flush with ready in REQ
        drive(1'b1, 32'hCAFE_F00D, 1'b1, 1'b0, 32'h404);
        next_cycle();
        drive(1'b1, 32'h0, 1'b1, 1'b1, 32'h404);
        push_clear();
        @(negedge clk);
        chk("t5_pc_set", {31'd0, pc_set}, 32'd1);
        chk("t5_set_low", {31'd0, dec_set}, 32'd0);
        next_cycle();
        drive(1'b1, 32'h00A0_0513, 1'b0, 1'b0, 32'h800);
        push_set(32'h00A0_0513);
        @(negedge clk);
        chk("t5_req_valid", {31'd0, valid}, 32'd1);
        chk("t5_req_addr", addr, 32'h800);
        next_cycle();
        drive(1'b1, 32'hFFFF_FFFF, 1'b0, 1'b1, 32'h804);
        push_clear();
        @(negedge clk);
        chk("t5_rflush_pc_set", {31'd0, pc_set}, 32'd1);
        next_cycle();
        drive(1'b1, 32'h0000_0001, 1'b0, 1'b0, 32'h900);
        push_set(32'h0000_0001);
        next_cycle();

        // 6: timeout after four unanswered cycles, sticky until reset
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h904);
            @(negedge clk);
            chk("t6_timeout_low", {31'd0, timeout}, 32'd0);
            next_cycle();
        end
        drive(1'b1, 32'h0000_0002, 1'b0, 1'b0, 32'h904);
        push_set(32'h0000_0002);
        @(negedge clk);
        chk("t6_timeout_set", {31'd0, timeout}, 32'd1);
        next_cycle();
        drive(1'b1, 32'h0000_0003, 1'b0, 1'b0, 32'h908);
        push_set(32'h0000_0003);
        @(negedge clk);
        chk("t6_timeout_sticky", {31'd0, timeout}, 32'd1);
        next_cycle();
        resetn = 1'b0;
        drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        @(negedge clk);
        chk("t6_reset_valid", {31'd0, valid}, 32'd0);
        next_cycle();
        resetn = 1'b1;
        @(negedge clk);
        chk("t6_timeout_cleared", {31'd0, timeout}, 32'd0);
        next_cycle();

        @(negedge clk);
        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
